// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline constants and the IF/ID bundle type.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int          c_DATA_W    = 32;
    localparam logic [31:0] c_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;

    // One IF/ID pipeline slot: fetched word, its PC+4, and a real/bubble flag.
    typedef struct packed {
        logic [c_DATA_W-1:0] instr;
        logic [c_DATA_W-1:0] pc4;
        logic                valid;
    } ifid_t;

    // Contents of the slot when it carries no instruction.
    localparam ifid_t c_IFID_BUBBLE = '{instr: c_NOP_INSTR, pc4: '0, valid: 1'b0};

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with load-enable (hold when low)
//               and clear (insert bubble). Clear beats enable.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import pipe_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_en,
    input  logic  i_clear,
    input  ifid_t i_d,
    output ifid_t o_q
);

    ifid_t r_q;

    // Slot update: reset/clear load a bubble, enable loads the new fetch, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= c_IFID_BUBBLE;
        end else if (i_clear) begin
            r_q <= c_IFID_BUBBLE;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Owns the PC, drives the instruction
//               memory address, fills the IF/ID register, and keeps
//               saturating fetch/stall performance counters.
//               Priority each cycle: reset > redirect > stall > fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_instr_i,
    output logic [31:0]      ifid_instr_o,
    output logic [31:0]      ifid_pc4_o,
    output logic             ifid_valid_o,
    output logic [CNT_W-1:0] fetch_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_fetch_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [31:0] w_pc4;
    logic        w_fetch;
    logic        w_stall_cnt_en;
    logic [31:0] w_target;
    logic        w_unused_tgt_bits;
    ifid_t       w_ifid_d;
    ifid_t       w_ifid_q;

    // Redirect wins over stall, so a stall only counts when no redirect is present.
    assign w_pc4          = r_pc + 32'd4;
    assign w_fetch        = !branch_taken_i && !stall_i;
    assign w_stall_cnt_en = stall_i && !branch_taken_i;
    // Targets are forced word-aligned; the low bits are deliberately dropped.
    assign w_target          = {branch_target_i[31:2], 2'b00};
    assign w_unused_tgt_bits = ^branch_target_i[1:0];

    // PC register: redirect, hold on stall, otherwise advance by one word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc <= RESET_PC;
        end else if (branch_taken_i) begin
            r_pc <= w_target;
        end else if (!stall_i) begin
            r_pc <= w_pc4;
        end
    end

    // Saturating performance counters for accepted fetches and stall cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_fetch && (r_fetch_cnt != c_CNT_MAX)) begin
                r_fetch_cnt <= r_fetch_cnt + c_CNT_ONE;
            end
            if (w_stall_cnt_en && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
        end
    end

    // Next IF/ID contents for a normal fetch.
    always_comb begin
        w_ifid_d       = c_IFID_BUBBLE;
        w_ifid_d.instr = imem_instr_i;
        w_ifid_d.pc4   = w_pc4;
        w_ifid_d.valid = 1'b1;
    end

    if_id_reg u_if_id_reg (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_en    (w_fetch),
        .i_clear (branch_taken_i),
        .i_d     (w_ifid_d),
        .o_q     (w_ifid_q)
    );

    assign imem_addr_o  = r_pc;
    assign ifid_instr_o = w_ifid_q.instr;
    assign ifid_pc4_o   = w_ifid_q.pc4;
    assign ifid_valid_o = w_ifid_q.valid;
    assign fetch_cnt_o  = r_fetch_cnt;
    assign stall_cnt_o  = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage. A second instance
//               with a high reset PC and 3-bit counters covers PC wrap and
//               counter saturation. Instruction memory returns its address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [31:0] target;

    logic [31:0] addr_a, instr_a, pc4_a;
    logic        valid_a;
    logic [31:0] fcnt_a, scnt_a;

    logic [31:0] addr_b, instr_b, pc4_b;
    logic        valid_b;
    logic [2:0]  fcnt_b, scnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut_a (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .branch_taken_i(branch),
        .branch_target_i(target), .imem_addr_o(addr_a), .imem_instr_i(addr_a),
        .ifid_instr_o(instr_a), .ifid_pc4_o(pc4_a), .ifid_valid_o(valid_a),
        .fetch_cnt_o(fcnt_a), .stall_cnt_o(scnt_a)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .branch_taken_i(branch),
        .branch_target_i(target), .imem_addr_o(addr_b), .imem_instr_i(addr_b),
        .ifid_instr_o(instr_b), .ifid_pc4_o(pc4_b), .ifid_valid_o(valid_b),
        .fetch_cnt_o(fcnt_b), .stall_cnt_o(scnt_b)
    );

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; branch = 1'b0; target = 32'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (addr_a !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp %h", addr_a, 32'h0); end
        n_tests++;
        if ({instr_a, pc4_a, valid_a} !== 65'h0) begin n_fail++;
            $display("FAIL reset_ifid got %h/%h/%b exp 0/0/0", instr_a, pc4_a, valid_a); end
        n_tests++;
        if ({fcnt_a, scnt_a} !== 64'h0) begin n_fail++;
            $display("FAIL reset_cnt got %0d/%0d exp 0/0", fcnt_a, scnt_a); end
        n_tests++;
        if (addr_b !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL reset_pc_b got %h exp fffffff8", addr_b); end
    endtask

    task automatic test_free_run();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_tests++;
            if (pc4_a !== 32'(4 * i) || instr_a !== 32'(4 * (i - 1)) || valid_a !== 1'b1) begin
                n_fail++;
                $display("FAIL free_run[%0d] got pc4=%h instr=%h v=%b exp pc4=%h instr=%h v=1",
                         i, pc4_a, instr_a, valid_a, 32'(4 * i), 32'(4 * (i - 1)));
            end
        end
        n_tests++;
        if (fcnt_a !== 32'd4) begin n_fail++; $display("FAIL free_run_cnt got %0d exp 4", fcnt_a); end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (addr_a !== 32'h8 || pc4_a !== 32'h8 || instr_a !== 32'h4 || valid_a !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] got addr=%h pc4=%h instr=%h v=%b exp 8/8/4/1",
                         i, addr_a, pc4_a, instr_a, valid_a);
            end
        end
        n_tests++;
        if (scnt_a !== 32'd3 || fcnt_a !== 32'd2) begin n_fail++;
            $display("FAIL stall_cnt got s=%0d f=%0d exp s=3 f=2", scnt_a, fcnt_a); end
        stall = 1'b0;
        tick();
        n_tests++;
        if (instr_a !== 32'h8 || pc4_a !== 32'hC || addr_a !== 32'hC) begin n_fail++;
            $display("FAIL stall_resume got instr=%h pc4=%h addr=%h exp 8/c/c", instr_a, pc4_a, addr_a); end
    endtask

    task automatic test_branch();
        do_reset();
        tick(); tick(); tick();
        branch = 1'b1; target = 32'h40;
        tick();
        branch = 1'b0;
        n_tests++;
        if (valid_a !== 1'b0 || instr_a !== 32'h0 || pc4_a !== 32'h0 || addr_a !== 32'h40) begin n_fail++;
            $display("FAIL branch_bubble got v=%b instr=%h pc4=%h addr=%h exp 0/0/0/40",
                     valid_a, instr_a, pc4_a, addr_a); end
        n_tests++;
        if (fcnt_a !== 32'd3) begin n_fail++; $display("FAIL branch_fcnt got %0d exp 3", fcnt_a); end
        tick();
        n_tests++;
        if (pc4_a !== 32'h44 || instr_a !== 32'h40 || valid_a !== 1'b1) begin n_fail++;
            $display("FAIL branch_target got pc4=%h instr=%h v=%b exp 44/40/1", pc4_a, instr_a, valid_a); end
    endtask

    task automatic test_branch_stall();
        logic [31:0] s_before;
        stall = 1'b1;
        tick();
        s_before = scnt_a;
        branch = 1'b1; target = 32'h81;
        tick();
        branch = 1'b0; stall = 1'b0;
        n_tests++;
        if (addr_a !== 32'h80 || valid_a !== 1'b0) begin n_fail++;
            $display("FAIL br_stall_pc got addr=%h v=%b exp 80/0", addr_a, valid_a); end
        n_tests++;
        if (scnt_a !== s_before || scnt_a !== 32'd1) begin n_fail++;
            $display("FAIL br_stall_cnt got %0d exp 1", scnt_a); end
    endtask

    task automatic test_back_to_back();
        branch = 1'b1; target = 32'h100;
        tick();
        target = 32'h200;
        tick();
        branch = 1'b0;
        n_tests++;
        if (addr_a !== 32'h200 || valid_a !== 1'b0) begin n_fail++;
            $display("FAIL b2b_pc got addr=%h v=%b exp 200/0", addr_a, valid_a); end
        tick();
        n_tests++;
        if (instr_a !== 32'h200 || pc4_a !== 32'h204 || valid_a !== 1'b1) begin n_fail++;
            $display("FAIL b2b_fetch got instr=%h pc4=%h v=%b exp 200/204/1", instr_a, pc4_a, valid_a); end
    endtask

    task automatic test_wrap_saturate();
        do_reset();
        tick();
        n_tests++;
        if (addr_b !== 32'hFFFF_FFFC || pc4_b !== 32'hFFFF_FFFC || instr_b !== 32'hFFFF_FFF8) begin n_fail++;
            $display("FAIL wrap_1 got addr=%h pc4=%h instr=%h exp fffffffc/fffffffc/fffffff8",
                     addr_b, pc4_b, instr_b); end
        tick();
        n_tests++;
        if (addr_b !== 32'h0 || pc4_b !== 32'h0 || instr_b !== 32'hFFFF_FFFC || valid_b !== 1'b1) begin n_fail++;
            $display("FAIL wrap_2 got addr=%h pc4=%h instr=%h v=%b exp 0/0/fffffffc/1",
                     addr_b, pc4_b, instr_b, valid_b); end
        for (int i = 0; i < 7; i++) tick();
        n_tests++;
        if (fcnt_b !== 3'd7 || fcnt_a !== 32'd9) begin n_fail++;
            $display("FAIL fetch_sat got b=%0d a=%0d exp 7/9", fcnt_b, fcnt_a); end
        stall = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        stall = 1'b0;
        n_tests++;
        if (scnt_b !== 3'd7 || scnt_a !== 32'd9) begin n_fail++;
            $display("FAIL stall_sat got b=%0d a=%0d exp 7/9", scnt_b, scnt_a); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        stall = 1'b1;
        tick();
        n_tests++;
        if (addr_a !== 32'h20 || scnt_a !== 32'd1) begin n_fail++;
            $display("FAIL pre_reset got addr=%h s=%0d exp 20/1", addr_a, scnt_a); end
        rst = 1'b1;
        tick();
        n_tests++;
        if (addr_a !== 32'h0 || fcnt_a !== 32'd0 || scnt_a !== 32'd0 || valid_a !== 1'b0) begin n_fail++;
            $display("FAIL mid_stall_reset got addr=%h f=%0d s=%0d v=%b exp 0/0/0/0",
                     addr_a, fcnt_a, scnt_a, valid_a); end
        rst = 1'b0; stall = 1'b0;
        tick();
        n_tests++;
        if (instr_a !== 32'h0 || pc4_a !== 32'h4 || valid_a !== 1'b1 || fcnt_a !== 32'd1) begin n_fail++;
            $display("FAIL first_fetch got instr=%h pc4=%h v=%b f=%0d exp 0/4/1/1",
                     instr_a, pc4_a, valid_a, fcnt_a); end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch = 1'b0; target = 32'h0;
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_branch_stall();
        test_back_to_back();
        test_wrap_saturate();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: CNT_W, 32, width of the performance counters.
REQ-003 Port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_i  input  1  synchronous, active-high reset, sampled on the rising edge of clk_i.
REQ-005 Port: stall_i  input  1  hazard-unit stall request; hold PC and IF/ID.
REQ-006 Port: branch_taken_i  input  1  redirect request from a later stage.
REQ-007 Port: branch_target_i  input  32  redirect target address.
REQ-008 Port: imem_addr_o  output  32  instruction-memory address; equals the current PC.
REQ-009 Port: imem_instr_i  input  32  instruction word at imem_addr_o, combinational, same cycle.
REQ-010 Port: ifid_instr_o  output  32  registered IF/ID instruction.
REQ-011 Port: ifid_pc4_o  output  32  registered IF/ID PC+4.
REQ-012 Port: ifid_valid_o  output  1  IF/ID holds a real (non-bubble) instruction.
REQ-013 Port: fetch_cnt_o  output  CNT_W  count of instructions accepted into IF/ID.
REQ-014 Port: stall_cnt_o  output  CNT_W  count of stall cycles.

Function
REQ-015 The block SHALL hold one PC register; imem_addr_o SHALL be driven directly from it with no extra latency.
REQ-016 Per-cycle priority SHALL be: reset > branch_taken_i > stall_i > normal fetch.
REQ-017 Normal fetch: PC <= PC+4; IF/ID <= {imem_instr_i, PC+4, valid=1}; fetch_cnt_o increments.
REQ-018 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), with no error.
REQ-019 Redirect: PC <= {branch_target_i[31:2], 2'b00}; IF/ID SHALL become a bubble (instr 32'h0, pc4 32'h0, valid 0); fetch_cnt_o SHALL NOT increment.
REQ-020 Stall: PC and all IF/ID fields SHALL hold their values; stall_cnt_o increments.
REQ-021 If branch_taken_i and stall_i are both asserted, the redirect SHALL take effect and the stall SHALL be ignored; stall_cnt_o SHALL NOT increment.
REQ-022 Redirect latency: the instruction at the target SHALL appear on ifid_instr_o exactly 2 cycles after the cycle in which branch_taken_i is sampled high.
REQ-023 Back-to-back redirects SHALL each take effect; the last sampled target wins.
REQ-024 Both counters SHALL saturate at all-ones, not wrap.
REQ-025 All outputs except imem_addr_o SHALL be registered.

Reset
REQ-026 While rst_i=1 at a clock edge, the block SHALL set PC=RESET_PC, ifid_instr_o=32'h0, ifid_pc4_o=32'h0, ifid_valid_o=0, fetch_cnt_o=0 and stall_cnt_o=0.
REQ-027 Reset asserted during a stall or redirect SHALL override it; the first fetch after release SHALL come from RESET_PC.
REQ-028 The first rising edge with rst_i=0 SHALL fetch from RESET_PC into IF/ID.

Structure
REQ-029 The shared package pipe_pkg SHALL hold the following:
- RESET_PC default
- NOP_INSTR (32'h0)
- data width constant (32)
- the IF/ID bundle typedef {instr, pc4, valid}
REQ-030 The IF/ID register SHALL be a sub-module if_id_reg with enable (hold) and clear (bubble) controls; the PC register and counters SHALL stay in if_stage.

Verification
REQ-031 The bench SHALL cover the following scenarios:
- Reset, then 4 free cycles with imem word = address: ifid_pc4_o sequence is 4, 8, 12, 16; fetch_cnt_o=4; valid=1.
- Stall held 3 cycles at PC=8: imem_addr_o stays 8; IF/ID is unchanged; stall_cnt_o=3; fetching resumes at 8.
- branch_taken_i with target 32'h40 at PC=12: next cycle valid=0 and imem_addr_o=32'h40; the following cycle ifid_pc4_o=32'h44.
- branch_taken_i and stall_i together, target 32'h81: PC becomes 32'h80; stall_cnt_o is unchanged.
- RESET_PC=32'hFFFF_FFF8 with 3 free cycles: imem_addr_o sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_i asserted mid-stall at PC=32'h20: next cycle PC=RESET_PC, counters=0, valid=0.
